// File: rtl/obi_req_driver.sv
// rtl/obi_req_driver.sv - OBI data-side initiator with random request gaps and an outstanding-command FIFO
module obi_req_driver #(
  parameter int DW         = 32,
  parameter int MAX_OUTSTD = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_ni,
  input  logic [3:0]                    REQ_WMAX,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [3:0]                    cmd_be,
  input  logic                          cmd_is_cap,
  input  logic                          cmd_is_lrsc,
  input  logic [31:0]                   cmd_addr,
  input  logic [DW-1:0]                 cmd_wdata,
  input  logic [7:0]                    cmd_flag,
  output logic                          data_req,
  output logic                          data_we,
  output logic [3:0]                    data_be,
  output logic                          data_is_cap,
  output logic                          data_is_lrsc,
  output logic [31:0]                   data_addr,
  output logic [DW-1:0]                 data_wdata,
  output logic [7:0]                    data_flag,
  input  logic                          data_gnt,
  input  logic                          data_rvalid,
  input  logic [DW-1:0]                 data_rdata,
  input  logic                          data_err,
  input  logic                          data_sc_resp,
  output logic                          rsp_valid,
  output logic                          rsp_we,
  output logic [3:0]                    rsp_be,
  output logic [7:0]                    rsp_flag,
  output logic [31:0]                   rsp_addr,
  output logic [DW-1:0]                 rsp_wdata,
  output logic [DW-1:0]                 rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_sc_resp,
  output logic [$clog2(MAX_OUTSTD):0]   outstd_cnt,
  output logic                          proto_err
);
  localparam int PW = $clog2(MAX_OUTSTD);
  localparam int EW = 1 + 4 + 8 + 32 + DW;        // FIFO entry: we, be, flag, addr, wdata
  localparam int AW = 1 + 4 + 1 + 1 + 32 + DW + 8; // all request attributes
  localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTSTD);

  typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cntr_q, cntr_d, draw_n;
  logic [31:0]   rng_q, rng_nxt;
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic [EW-1:0] fifo_mem [MAX_OUTSTD];
  logic [EW-1:0] fifo_head;
  logic          fifo_empty, fifo_full, grant, accept, pop;
  logic [AW-1:0] attr_now, attr_q;
  logic          req_pend_q;

  assign outstd_cnt = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (outstd_cnt == FULL_CNT);
  assign data_req   = (state_q == REQ) && !fifo_full;
  assign grant      = data_req && data_gnt;
  assign cmd_ready  = (state_q == IDLE) || grant;
  assign accept     = cmd_valid && cmd_ready;
  assign pop        = data_rvalid && !fifo_empty;

  // Idle-gap draw: half the time zero, otherwise uniform-ish in 0..REQ_WMAX
  assign draw_n = (REQ_WMAX == 4'd0 || !rng_q[31]) ? 4'd0
                : 4'(rng_q[15:0] % ({12'd0, REQ_WMAX} + 16'd1));

  // xorshift32 step; the generator advances once per accepted command
  always_comb begin
    rng_nxt = rng_q ^ (rng_q << 13);
    rng_nxt = rng_nxt ^ (rng_nxt >> 17);
    rng_nxt = rng_nxt ^ (rng_nxt << 5);
  end

  // Next-state logic: accept -> REQ directly or via a WAIT countdown
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (draw_n == 4'd0) ? REQ : WAIT;
          cntr_d  = draw_n;
        end
      end
      WAIT: begin
        cntr_d = cntr_q - 4'd1;
        if (cntr_q == 4'd1) state_d = REQ;
      end
      REQ: begin
        if (grant) begin
          state_d = IDLE;
          if (accept) begin
            state_d = (draw_n == 4'd0) ? REQ : WAIT;
            cntr_d  = draw_n;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, countdown and random generator registers
  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cntr_q  <= 4'd0;
      rng_q   <= 32'h2545_F491;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      if (accept) rng_q <= rng_nxt;
    end
  end

  // Latched command drives the request attributes until the next accept
  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      data_we      <= 1'b0;
      data_be      <= 4'd0;
      data_is_cap  <= 1'b0;
      data_is_lrsc <= 1'b0;
      data_addr    <= 32'd0;
      data_wdata   <= '0;
      data_flag    <= 8'd0;
    end else if (accept) begin
      data_we      <= cmd_we;
      data_be      <= cmd_be;
      data_is_cap  <= cmd_is_cap;
      data_is_lrsc <= cmd_is_lrsc;
      data_addr    <= cmd_addr;
      data_wdata   <= cmd_wdata;
      data_flag    <= cmd_flag;
    end
  end

  // Outstanding FIFO pointers: push on grant, pop on a matched response
  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage holds the granted command for response pairing
  always_ff @(posedge clk_wr) begin
    if (grant) fifo_mem[wr_ptr_q[PW-1:0]] <= {data_we, data_be, data_flag, data_addr, data_wdata};
  end

  assign fifo_head = fifo_mem[rd_ptr_q[PW-1:0]];
  assign {rsp_we, rsp_be, rsp_flag, rsp_addr, rsp_wdata} = fifo_head;
  assign rsp_valid   = pop;
  assign rsp_rdata   = rsp_valid ? data_rdata : '0;
  assign rsp_err     = rsp_valid && data_err;
  assign rsp_sc_resp = rsp_valid && data_sc_resp;

  assign attr_now = {data_we, data_be, data_is_cap, data_is_lrsc, data_addr, data_wdata, data_flag};

  // Snapshot of a pending (ungranted) request for the stability self-check
  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pend_q <= 1'b0;
      attr_q     <= '0;
    end else begin
      req_pend_q <= data_req && !data_gnt;
      attr_q     <= attr_now;
    end
  end

  // Sticky protocol-violation flag
  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err <= 1'b0;
    end else if ((data_gnt && !data_req) || (data_rvalid && fifo_empty) ||
                 (req_pend_q && data_req && (attr_now != attr_q))) begin
      proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_req_driver.sv
// tb/tb_obi_req_driver.sv - scoreboard bench for obi_req_driver with a queue-based reference model
module tb_obi_req_driver;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic        cap;
    logic        lrsc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  flag;
  } cmd_t;

  logic          clk_wr = 1'b0;
  logic          rst_ni = 1'b0;
  logic [3:0]    wmax = 4'd0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic          cmd_we = 1'b0, cmd_is_cap = 1'b0, cmd_is_lrsc = 1'b0;
  logic [3:0]    cmd_be = 4'd0;
  logic [31:0]   cmd_addr = 32'd0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [7:0]    cmd_flag = 8'd0;
  logic          data_req, data_we, data_is_cap, data_is_lrsc;
  logic [3:0]    data_be;
  logic [31:0]   data_addr;
  logic [DW-1:0] data_wdata;
  logic [7:0]    data_flag;
  logic          data_gnt = 1'b0, data_rvalid = 1'b0, data_err = 1'b0, data_sc_resp = 1'b0;
  logic [DW-1:0] data_rdata = '0;
  logic          rsp_valid, rsp_we, rsp_err, rsp_sc_resp;
  logic [3:0]    rsp_be;
  logic [7:0]    rsp_flag;
  logic [31:0]   rsp_addr;
  logic [DW-1:0] rsp_wdata, rsp_rdata;
  logic [$clog2(MAXO):0] outstd_cnt;
  logic          proto_err;

  obi_req_driver #(.DW(DW), .MAX_OUTSTD(MAXO)) dut (
    .clk_wr(clk_wr), .rst_ni(rst_ni), .REQ_WMAX(wmax),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_be(cmd_be),
    .cmd_is_cap(cmd_is_cap), .cmd_is_lrsc(cmd_is_lrsc), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_flag(cmd_flag),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_is_cap(data_is_cap),
    .data_is_lrsc(data_is_lrsc), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_flag(data_flag), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err), .data_sc_resp(data_sc_resp),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_be(rsp_be), .rsp_flag(rsp_flag),
    .rsp_addr(rsp_addr), .rsp_wdata(rsp_wdata), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_sc_resp(rsp_sc_resp), .outstd_cnt(outstd_cnt), .proto_err(proto_err)
  );

  always #5 clk_wr = ~clk_wr;

  int   checks = 0, errors = 0;
  cmd_t cmd_src[$];              // commands waiting to be offered
  cmd_t exp_req[$];              // accepted, not yet granted
  cmd_t outst[$];                // granted, awaiting response
  logic [7:0] rsp_log[$];
  int   gnt_cycles[$];
  int   cyc = 0, req_run = 0, last_req_len = 0;
  bit   model_err = 0, acc_evt = 0, prev_pend = 0;
  cmd_t prev_attr;
  int   gnt_mode = 0, gnt_dly = 0, vld_pct = 100;
  bit   rv_en = 1, rv_rand = 0, rv_one = 0, inj_rv = 0, inj_gnt = 0;
  bit   gap_en = 0, gap_pend = 0, gap_blk = 0;
  int   gap_cnt = 0, n_gap = 0, n_zero = 0, n_max = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [7:0] flag);
    cmd_t c;
    c.we = we; c.be = 4'($urandom); c.cap = 1'($urandom); c.lrsc = 1'($urandom);
    c.addr = addr; c.wdata = $urandom; c.flag = flag;
    cmd_src.push_back(c);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (!(cmd_src.size() == 0 && exp_req.size() == 0 && outst.size() == 0) && n < max) begin
      @(negedge clk_wr); n++;
    end
    chk(name, 96'(n < max), 96'd1);
    @(negedge clk_wr);
  endtask

  task automatic reset_pulse(input string name);
    @(posedge clk_wr); #3; rst_ni = 1'b0;
    repeat (2) @(posedge clk_wr);
    @(negedge clk_wr);
    chk({name, "_req"},   96'(data_req), 96'd0);
    chk({name, "_cnt"},   96'(outstd_cnt), 96'd0);
    chk({name, "_err"},   96'(proto_err), 96'd0);
    chk({name, "_addr"},  96'(data_addr), 96'd0);
    chk({name, "_ready"}, 96'(cmd_ready), 96'd1);
    chk({name, "_rsp"},   96'(rsp_valid), 96'd0);
    @(posedge clk_wr); #2; rst_ni = 1'b1;
    @(negedge clk_wr);
  endtask

  // Monitor/scoreboard: samples on the falling edge, pairs events with the model queues
  always @(negedge clk_wr) begin
    cmd_t d, e;
    cyc++;
    d = {data_we, data_be, data_is_cap, data_is_lrsc, data_addr, data_wdata, data_flag};
    if (!rst_ni) begin
      exp_req.delete(); outst.delete();
      model_err = 0; acc_evt = 0; prev_pend = 0; gap_pend = 0; req_run = 0;
    end else begin
      chk("outstd_cnt", 96'(outstd_cnt), 96'(outst.size()));
      chk("proto_err", 96'(proto_err), 96'(model_err));
      if (outst.size() == MAXO) chk("full_req_low", 96'(data_req), 96'd0);
      if (!data_rvalid) chk("rsp_quiet", 96'(rsp_valid), 96'd0);
      if (prev_pend && data_req) chk("attr_stable", 96'(d), 96'(prev_attr));
      if (gap_pend) begin
        gap_cnt++;
        if (outst.size() == MAXO) gap_blk = 1;
        if (data_req) begin
          gap_pend = 0;
          if (gap_en && !gap_blk) begin
            chk("gap_range", 96'(gap_cnt >= 1 && gap_cnt <= int'(wmax) + 1), 96'd1);
            n_gap++;
            if (gap_cnt == 1) n_zero++;
            if (gap_cnt == int'(wmax) + 1) n_max++;
          end
        end
      end
      if (data_rvalid) begin
        if (outst.size() > 0) begin
          e = outst.pop_front();
          chk("rsp_valid", 96'(rsp_valid), 96'd1);
          chk("rsp_addr", 96'(rsp_addr), 96'(e.addr));
          chk("rsp_we", 96'(rsp_we), 96'(e.we));
          chk("rsp_be", 96'(rsp_be), 96'(e.be));
          chk("rsp_flag", 96'(rsp_flag), 96'(e.flag));
          chk("rsp_wdata", 96'(rsp_wdata), 96'(e.wdata));
          chk("rsp_rdata", 96'(rsp_rdata), 96'(data_rdata));
          chk("rsp_err", 96'(rsp_err), 96'(data_err));
          chk("rsp_sc", 96'(rsp_sc_resp), 96'(data_sc_resp));
          rsp_log.push_back(e.flag);
        end else begin
          chk("rsp_valid_empty", 96'(rsp_valid), 96'd0);
          model_err = 1;
        end
      end
      if (data_gnt && !data_req) model_err = 1;
      if (data_req && data_gnt) begin
        chk("gnt_has_cmd", 96'(exp_req.size() > 0), 96'd1);
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          chk("req_attrs", 96'(d), 96'(e));
          outst.push_back(e);
        end
        gnt_cycles.push_back(cyc);
        last_req_len = req_run + 1;
        req_run = 0;
      end else if (data_req) req_run++;
      else req_run = 0;
      if (cmd_valid && cmd_ready) begin
        exp_req.push_back({cmd_we, cmd_be, cmd_is_cap, cmd_is_lrsc, cmd_addr, cmd_wdata, cmd_flag});
        gap_pend = 1; gap_cnt = 0; gap_blk = 0;
      end
      acc_evt = cmd_valid && cmd_ready;
      prev_pend = data_req && !data_gnt;
      prev_attr = d;
    end
  end

  // Driver: command source and memory-model responder, updated just after each rising edge
  initial begin
    cmd_t c;
    forever begin
      @(posedge clk_wr); #1;
      if (acc_evt && cmd_src.size() > 0) begin
        c = cmd_src.pop_front();
        cmd_valid = 1'b0;
      end
      if (!cmd_valid && cmd_src.size() > 0 && $urandom_range(99) < vld_pct) begin
        c = cmd_src[0];
        {cmd_we, cmd_be, cmd_is_cap, cmd_is_lrsc, cmd_addr, cmd_wdata, cmd_flag} = c;
        cmd_valid = 1'b1;
      end
      if (inj_gnt) data_gnt = 1'b1;
      else case (gnt_mode)
        0:       data_gnt = data_req;
        1:       data_gnt = data_req && ($urandom_range(1) == 1);
        2:       data_gnt = data_req && (req_run >= gnt_dly);
        default: data_gnt = 1'b0;
      endcase
      if (inj_rv) data_rvalid = 1'b1;
      else if (outst.size() > 0) data_rvalid = rv_one || (rv_en && (!rv_rand || $urandom_range(1) == 1));
      else data_rvalid = 1'b0;
      data_rdata   = $urandom;
      data_err     = 1'($urandom_range(1));
      data_sc_resp = 1'($urandom_range(1));
    end
  end

  // Watchdog: the run always reaches the summary line
  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Directed scenarios followed by a long randomized stream
  initial begin
    int g0, n;
    repeat (3) @(posedge clk_wr);
    @(negedge clk_wr);
    chk("reset_ready", 96'(cmd_ready), 96'd1);
    chk("reset_req", 96'(data_req), 96'd0);
    chk("reset_cnt", 96'(outstd_cnt), 96'd0);
    chk("reset_err", 96'(proto_err), 96'd0);
    @(posedge clk_wr); #2; rst_ni = 1'b1;
    @(negedge clk_wr);

    // Zero-wait writes: back-to-back grants, responses in order
    wmax = 4'd0; gnt_mode = 0; rv_en = 1; rv_rand = 0; vld_pct = 100;
    gnt_cycles.delete(); rsp_log.delete();
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 32'h100 + 32'(4 * i), 8'(i));
    wait_idle("t1_idle", 200);
    chk("t1_gnts", 96'(gnt_cycles.size()), 96'd3);
    if (gnt_cycles.size() == 3) begin
      chk("t1_b2b_1", 96'(gnt_cycles[1] - gnt_cycles[0]), 96'd1);
      chk("t1_b2b_2", 96'(gnt_cycles[2] - gnt_cycles[1]), 96'd1);
    end
    chk("t1_rsps", 96'(rsp_log.size()), 96'd3);
    for (int i = 0; i < 3 && i < rsp_log.size(); i++) chk("t1_flag", 96'(rsp_log[i]), 96'(i));

    // Grant delayed 3 cycles: request held 4 cycles
    g0 = gnt_cycles.size();
    gnt_mode = 2; gnt_dly = 3;
    push_cmd(1'b0, 32'h200, 8'h10);
    wait_idle("t2_idle", 200);
    chk("t2_req_len", 96'(last_req_len), 96'd4);
    chk("t2_gnts", 96'(gnt_cycles.size() - g0), 96'd1);
    chk("t2_err", 96'(proto_err), 96'd0);

    // Full outstanding FIFO blocks the request until a response frees an entry
    g0 = gnt_cycles.size();
    gnt_mode = 0; rv_en = 0;
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 32'h300 + 32'(4 * i), 8'(8'h20 + i));
    n = 0;
    while (outst.size() < MAXO && n < 100) begin @(negedge clk_wr); n++; end
    repeat (3) @(negedge clk_wr);
    chk("t3_cnt", 96'(outstd_cnt), 96'd4);
    chk("t3_req_low", 96'(data_req), 96'd0);
    chk("t3_gnts", 96'(gnt_cycles.size() - g0), 96'd4);
    rv_one = 1;
    @(negedge clk_wr);
    chk("t3_rv_seen", 96'(data_rvalid), 96'd1);
    rv_one = 0;
    @(negedge clk_wr);
    chk("t3_req_again", 96'(data_req), 96'd1);
    chk("t3_cnt3", 96'(outstd_cnt), 96'd3);
    rv_en = 1;
    wait_idle("t3_idle", 300);

    // Simultaneous grant and response at two outstanding
    rv_en = 0; gnt_mode = 0;
    push_cmd(1'b0, 32'h400, 8'h30);
    push_cmd(1'b1, 32'h404, 8'h31);
    n = 0;
    while (!(outst.size() == 2 && cmd_src.size() == 0) && n < 100) begin @(negedge clk_wr); n++; end
    gnt_mode = 3;
    push_cmd(1'b0, 32'h408, 8'h32);
    n = 0;
    while (!data_req && n < 100) begin @(negedge clk_wr); n++; end
    gnt_mode = 0; rv_one = 1;
    @(negedge clk_wr);
    chk("t4_both", 96'(data_gnt && data_rvalid), 96'd1);
    chk("t4_rsp_addr", 96'(rsp_addr), 96'h400);
    rv_one = 0;
    @(negedge clk_wr);
    chk("t4_cnt", 96'(outstd_cnt), 96'd2);
    rv_en = 1;
    wait_idle("t4_idle", 300);

    // Protocol violations: stray response, then stray grant
    inj_rv = 1;
    @(negedge clk_wr);
    chk("t5_rv_seen", 96'(data_rvalid), 96'd1);
    chk("t5_rsp_valid", 96'(rsp_valid), 96'd0);
    inj_rv = 0;
    @(negedge clk_wr);
    chk("t5_err_rv", 96'(proto_err), 96'd1);
    repeat (5) @(negedge clk_wr);
    chk("t5_err_sticky", 96'(proto_err), 96'd1);
    reset_pulse("t5_rst1");
    inj_gnt = 1;
    @(negedge clk_wr);
    chk("t5_gnt_seen", 96'(data_gnt && !data_req), 96'd1);
    inj_gnt = 0;
    @(negedge clk_wr);
    chk("t5_err_gnt", 96'(proto_err), 96'd1);
    repeat (3) @(negedge clk_wr);
    chk("t5_err_gnt_sticky", 96'(proto_err), 96'd1);
    reset_pulse("t5_rst2");

    // Random stream with idle gaps up to 5 and a reset pulse mid-stream
    wmax = 4'd5; gnt_mode = 1; rv_en = 1; rv_rand = 1; vld_pct = 70;
    gap_en = 1; n_gap = 0; n_zero = 0; n_max = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      a = $urandom; a[1:0] = 2'b00;
      push_cmd(1'($urandom), a, 8'(i));
    end
    n = 0;
    while (cmd_src.size() > 600 && n < 20000) begin @(negedge clk_wr); n++; end
    chk("t6_progress", 96'(n < 20000), 96'd1);
    reset_pulse("t6_rst");
    wait_idle("t6_idle", 60000);
    chk("t6_err", 96'(proto_err), 96'd0);
    chk("t6_gap_samples", 96'(n_gap > 500), 96'd1);
    chk("t6_zero_frac", 96'(n_gap > 0 && n_zero * 100 >= n_gap * 45 && n_zero * 100 <= n_gap * 72), 96'd1);
    chk("t6_max_gap_seen", 96'(n_max > 0), 96'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
